// File: rtl/spi_master_seq.sv
// rtl/spi_master_seq.sv - SPI master sequencer: serialises 10-bit command words onto SS_n/MOSI
// and captures an 8-bit MISO reply for read-data frames.
module spi_master_seq #(
    parameter int RD_LATENCY = 2,
    parameter int GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [9:0] cmd_word,
    output logic       rsp_valid,
    output logic       rsp_is_read,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_CMD,
        ST_SHIFT,
        ST_WAIT,
        ST_CAPTURE,
        ST_GAP
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(RD_LATENCY - 1);
    localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [9:0] word_q, word_d;
    logic [7:0] rx_q, rx_d;
    logic       cmd_ready_q, cmd_ready_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic       rsp_is_read_q, rsp_is_read_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic       busy_q, busy_d;
    logic       ss_n_q, ss_n_d;
    logic       mosi_q, mosi_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            word_q        <= '0;
            rx_q          <= '0;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_is_read_q <= 1'b0;
            rsp_data_q    <= '0;
            busy_q        <= 1'b0;
            ss_n_q        <= 1'b1;
            mosi_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            word_q        <= word_d;
            rx_q          <= rx_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_is_read_q <= rsp_is_read_d;
            rsp_data_q    <= rsp_data_d;
            busy_q        <= busy_d;
            ss_n_q        <= ss_n_d;
            mosi_q        <= mosi_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        rx_d    = rx_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    word_d  = cmd_word;
                    cnt_d   = '0;
                    state_d = ST_LEAD;
                end
            end
            ST_LEAD: state_d = ST_CMD;
            ST_CMD: begin
                cnt_d   = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (cnt_q == 4'd9) begin
                    cnt_d = '0;
                    if (word_q[9:8] == 2'b11) begin
                        state_d = (RD_LATENCY > 0) ? ST_WAIT : ST_CAPTURE;
                    end else begin
                        state_d = ST_GAP;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_CAPTURE: begin
                // First sample lands in bit 0 and ends up as data bit 7 after eight shifts.
                rx_d = {rx_q[6:0], MISO};
                if (cnt_q == 4'd7) begin
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so each pin lines up with the state it belongs to.
    always_comb begin
        cmd_ready_d   = (state_d == ST_IDLE);
        busy_d        = (state_d != ST_IDLE);
        ss_n_d        = (state_d == ST_IDLE) || (state_d == ST_GAP);
        mosi_d        = 1'b0;
        rsp_valid_d   = (state_d == ST_GAP) && (state_q != ST_GAP);
        rsp_is_read_d = rsp_is_read_q;
        rsp_data_d    = rsp_data_q;

        if (state_d == ST_CMD) begin
            mosi_d = word_d[9];
        end else if (state_d == ST_SHIFT) begin
            mosi_d = word_d[4'd9 - cnt_d];
        end

        if (rsp_valid_d) begin
            rsp_is_read_d = (word_q[9:8] == 2'b11);
            rsp_data_d    = (word_q[9:8] == 2'b11) ? rx_d : 8'h00;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_is_read = rsp_is_read_q;
    assign rsp_data    = rsp_data_q;
    assign busy        = busy_q;
    assign SS_n        = ss_n_q;
    assign MOSI        = mosi_q;

endmodule

// File: tb/tb_spi_master_seq.sv
// tb/tb_spi_master_seq.sv - randomized self-checking bench for spi_master_seq with a behavioural SPI slave.
module tb_spi_master_seq;

    localparam int RL = 2;
    localparam int GC = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [9:0] cmd_word = '0;
    logic       MISO = 1'b0;
    logic       cmd_ready;
    logic       rsp_valid;
    logic       rsp_is_read;
    logic [7:0] rsp_data;
    logic       busy;
    logic       SS_n;
    logic       MOSI;

    spi_master_seq #(.RD_LATENCY(RL), .GAP_CYCLES(GC)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_word   (cmd_word),
        .rsp_valid  (rsp_valid),
        .rsp_is_read(rsp_is_read),
        .rsp_data   (rsp_data),
        .busy       (busy),
        .SS_n       (SS_n),
        .MOSI       (MOSI),
        .MISO       (MISO)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: accepted commands in order, plus a simple address/memory slave.
    logic [9:0] exp_q[$];
    logic [7:0] mem[256];
    logic [7:0] slv_addr = '0;
    bit         ovr_en = 1'b0;
    logic [7:0] ovr_byte = '0;

    bit         in_frame = 1'b0;
    int         k = 0;
    logic [11:0] head;
    int         tail_ones;
    logic [9:0] cur_w;
    logic [7:0] reply;
    int         frames_done = 0;
    int         last_rise_cyc = 0;
    int         last_accept_cyc = 0;
    int         last_len = 0;
    logic [7:0] last_rsp_data = '0;
    logic       last_rsp_read = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            in_frame = 1'b0;
        end else begin
            if (SS_n == 1'b0) begin
                if (!in_frame) begin
                    in_frame  = 1'b1;
                    k         = 0;
                    head      = '0;
                    tail_ones = 0;
                    if (exp_q.size() == 0) begin
                        check("frame_unexpected", 32'd1, 32'd0);
                        cur_w = '0;
                    end else begin
                        cur_w = exp_q.pop_front();
                    end
                    reply = ovr_en ? ovr_byte : mem[slv_addr];
                end
                if (k < 12) head = {head[10:0], MOSI};
                else tail_ones += int'(MOSI);
                if (cur_w[9:8] == 2'b11 && k >= 12 + RL && k < 20 + RL)
                    MISO = reply[7 - (k - 12 - RL)];
                else
                    MISO = 1'($urandom);
                k++;
            end else if (in_frame) begin
                in_frame = 1'b0;
                frames_done++;
                last_rise_cyc = cyc;
                last_len = k;
                check("ss_len", k, (cur_w[9:8] == 2'b11) ? 20 + RL : 12);
                check("mosi_head", 32'(head), 32'({1'b0, cur_w[9], cur_w}));
                check("mosi_tail", tail_ones, 0);
                check("rsp_valid", 32'(rsp_valid), 32'd1);
                check("rsp_is_read", 32'(rsp_is_read), 32'(cur_w[9:8] == 2'b11));
                check("rsp_data", 32'(rsp_data), (cur_w[9:8] == 2'b11) ? 32'(reply) : 32'd0);
                check("busy_gap", 32'(busy), 32'd1);
                last_rsp_data = rsp_data;
                last_rsp_read = rsp_is_read;
                case (cur_w[9:8])
                    2'b00, 2'b10: slv_addr = cur_w[7:0];
                    2'b01:        mem[slv_addr] = cur_w[7:0];
                    default:      ;
                endcase
                MISO = 1'($urandom);
            end else begin
                if (rsp_valid) check("rsp_stray", 32'(rsp_valid), 32'd0);
                MISO = 1'($urandom);
            end
            if (rsp_valid) check("rsp_ready_overlap", 32'(cmd_ready), 32'd0);
        end
    end

    task automatic send(input logic [9:0] w);
        cmd_word  = w;
        cmd_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (cmd_ready) begin
                exp_q.push_back(w);
                last_accept_cyc = cyc + 1;
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        check("accept_timeout", 32'd0, 32'd1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        for (int i = 0; i < 3000; i++) begin
            if (frames_done >= target) return;
            @(negedge clk);
        end
        check("frame_timeout", 32'(frames_done), 32'(target));
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    int base;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

        repeat (3) @(negedge clk);
        check("rst_ss_n", 32'(SS_n), 32'd1);
        check("rst_mosi", 32'(MOSI), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);

        rst = 1'b0;
        @(negedge clk);
        check("idle_ss_n", 32'(SS_n), 32'd1);
        check("idle_mosi", 32'(MOSI), 32'd0);
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_rsp_valid", 32'(rsp_valid), 32'd0);

        // Single write-address frame with a known bit pattern.
        send(10'b00_1010_0101);
        cmd_valid = 1'b0;
        wait_frames(1);
        check("wr_len", last_len, 12);
        check("wr_rsp_read", 32'(last_rsp_read), 32'd0);

        // Write then read back through the slave model.
        send({2'b00, 8'h3C}); cmd_valid = 1'b0;
        send({2'b01, 8'hA7}); cmd_valid = 1'b0;
        send({2'b10, 8'h3C}); cmd_valid = 1'b0;
        send({2'b11, 8'h00}); cmd_valid = 1'b0;
        wait_frames(5);
        check("wrap_rd_read", 32'(last_rsp_read), 32'd1);
        check("wrap_rd_data", 32'(last_rsp_data), 32'hA7);

        // Read-data frame with MISO pattern 1,0,1,1,0,0,1,0.
        ovr_en = 1'b1;
        ovr_byte = 8'hB2;
        send({2'b11, 8'h55}); cmd_valid = 1'b0;
        wait_frames(6);
        ovr_en = 1'b0;
        check("b2_data", 32'(last_rsp_data), 32'hB2);
        check("b2_len", last_len, 22);

        // Valid held high across two commands.
        base = frames_done;
        send({2'b01, 8'($urandom)});
        send({2'b11, 8'($urandom)});
        cmd_valid = 1'b0;
        check("b2b_gap", last_accept_cyc - last_rise_cyc, GC + 1);
        wait_frames(base + 2);
        repeat (40) @(negedge clk);
        check("b2b_count", frames_done - base, 2);
        check("b2b_queue", exp_q.size(), 0);

        // Reset during SHIFT bit 5 abandons the frame.
        send({2'b11, 8'h81});
        cmd_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_ss_n", 32'(SS_n), 32'd1);
        check("mid_rst_mosi", 32'(MOSI), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_queue", exp_q.size(), 0);
        base = frames_done;
        send({2'b01, 8'h5A}); cmd_valid = 1'b0;
        wait_frames(base + 1);
        check("post_rst_frames", frames_done - base, 1);

        // Randomized command stream with random idle gaps.
        base = frames_done;
        for (int n = 0; n < 30; n++) begin
            send(10'($urandom));
            if ($urandom_range(0, 2) != 0) begin
                cmd_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        cmd_valid = 1'b0;
        wait_frames(base + 30);
        repeat (40) @(negedge clk);
        check("rand_frames", frames_done - base, 30);
        check("rand_queue", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
